// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: the extended ALU op codes handled by the
// multi-cycle MUL/DIV/MOD unit and its controller state encoding.
package ex_pkg;

    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_DIV = 4'b0100;
    localparam logic [3:0] OP_MOD = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/int_muldiv_unit_if.sv
// EX-stage request/response bundle between the pipeline (master) and the
// multi-cycle MUL/DIV/MOD unit (slave).
interface int_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            sel;
    logic [3:0]      op;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            flush;
    logic [XLEN-1:0] Z;
    logic            stall;
    logic            done;

    modport master (output sel, op, A, B, flush, input Z, stall, done);
    modport slave  (input sel, op, A, B, flush, output Z, stall, done);
endinterface

// File: rtl/muldiv_datapath.sv
// Radix-2 magnitude datapath: MSB-first shift-add multiply and restoring
// divide over |A|,|B|, with the sign fixup applied on the fix strobe.
module muldiv_datapath
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0] acc_reg;
    logic [XLEN-1:0] q_reg;
    logic [XLEN-1:0] m_reg;
    logic            is_mul_reg;
    logic            is_div_reg;
    logic            neg_reg;
    logic            div_zero_reg;

    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] shifted_lo;
    logic [XLEN-1:0] mul_sum;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] fixed;

    assign sign_a = a[XLEN-1];
    assign sign_b = b[XLEN-1];
    // Negating MIN yields 2**(XLEN-1), which is exactly its unsigned magnitude.
    assign mag_a  = sign_a ? -a : a;
    assign mag_b  = sign_b ? -b : b;

    // q_reg feeds bits MSB-first: multiplier bits for MUL, dividend bits for DIV/MOD.
    assign trial      = {acc_reg, q_reg[XLEN-1]} - {1'b0, m_reg};
    assign shifted_lo = {acc_reg[XLEN-2:0], q_reg[XLEN-1]};
    assign mul_sum    = {acc_reg[XLEN-2:0], 1'b0} + (q_reg[XLEN-1] ? m_reg : '0);

    assign raw   = is_div_reg ? q_reg : acc_reg;
    assign fixed = neg_reg ? -raw : raw;

    always_comb begin
        result = '0;
        if (fix) begin
            result = (is_div_reg && div_zero_reg) ? '1 : fixed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= '0;
            q_reg        <= '0;
            m_reg        <= '0;
            is_mul_reg   <= 1'b0;
            is_div_reg   <= 1'b0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (load) begin
            is_mul_reg   <= (op == OP_MUL);
            is_div_reg   <= (op == OP_DIV);
            div_zero_reg <= (b == '0);
            neg_reg      <= (op == OP_MOD) ? sign_a : (sign_a ^ sign_b);
            acc_reg      <= '0;
            q_reg        <= (op == OP_MUL) ? mag_b : mag_a;
            m_reg        <= (op == OP_MUL) ? mag_a : mag_b;
        end else if (step) begin
            if (is_mul_reg) begin
                acc_reg <= mul_sum;
                q_reg   <= {q_reg[XLEN-2:0], 1'b0};
            end else if (!trial[XLEN]) begin
                acc_reg <= trial[XLEN-1:0];
                q_reg   <= {q_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_reg <= shifted_lo;
                q_reg   <= {q_reg[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/int_muldiv_unit.sv
// Multi-cycle signed MUL/DIV/MOD responder for EX: accepts one request,
// freezes the pipeline via stall, and pulses done with the result in Z.
module int_muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    int_muldiv_unit_if.slave bus
);
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [XLEN-1:0]  z_reg;
    logic [XLEN-1:0]  z_next;
    logic             done_reg;
    logic             done_next;

    logic             req;
    logic             accept;
    logic             load;
    logic             step;
    logic             fix;
    logic [XLEN-1:0]  dp_result;

    assign req = bus.sel && is_muldiv_op(bus.op);
    // The done cycle belongs to the completing instruction, so no accept then.
    assign accept = req && (state_reg == IDLE) && !done_reg && !bus.flush;

    assign bus.stall = accept || (state_reg != IDLE);
    assign bus.done  = done_reg;
    assign bus.Z     = z_reg;

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .fix   (fix),
        .op    (bus.op),
        .a     (bus.A),
        .b     (bus.B),
        .result(dp_result)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        z_next     = z_reg;
        done_next  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                    cnt_next   = CNT_W'(XLEN - 1);
                    load       = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = FIX;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            FIX: begin
                fix        = 1'b1;
                state_next = IDLE;
                if (!bus.flush) begin
                    done_next = 1'b1;
                    z_next    = dp_result;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            z_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            z_reg     <= z_next;
            done_reg  <= done_next;
        end
    end

endmodule
